// File: rtl/baud_rate_tick_gen.sv
// baud_rate_tick_gen: UART baud-tick generator.
// Produces a one-cycle TX strobe (intx) at the selected baud rate and a
// one-cycle RX strobe (inrx) at 16x the baud rate, both as clock enables
// for logic running on clk. All divisors are fixed at elaboration time.
// Optional feature macro: BAUD_TX_FROM_RX_EN -- derive intx from every
// 16th inrx instead of running an independent TX divider.
module baud_rate_tick_gen #(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] baud_sel,
    output logic       intx,
    output logic       inrx
);

    localparam longint unsigned FREQ   = longint'(CLK_FREQ);
    localparam longint unsigned BAUD_0 = 64'd9600;
    localparam longint unsigned BAUD_1 = 64'd4800;
    localparam longint unsigned BAUD_2 = 64'd19200;
    localparam longint unsigned BAUD_3 = 64'd460800;

    // Rounded 16x-oversample divisor, computed in 64 bits so large clocks cannot overflow.
    function automatic logic [31:0] rx_div(input longint unsigned baud);
        longint unsigned q;
        q = (FREQ + 64'd8 * baud) / (64'd16 * baud);
        return q[31:0];
    endfunction

    // Terminal counts (DIV-1) for the RX divider, one per rate select.
    localparam logic [31:0] RX_LIM_0 = rx_div(BAUD_0) - 32'd1;
    localparam logic [31:0] RX_LIM_1 = rx_div(BAUD_1) - 32'd1;
    localparam logic [31:0] RX_LIM_2 = rx_div(BAUD_2) - 32'd1;
    localparam logic [31:0] RX_LIM_3 = rx_div(BAUD_3) - 32'd1;

    logic [1:0]  sel_q;
    logic        rate_change;
    logic [31:0] rx_cnt;
    logic [31:0] rx_lim;
    logic        rx_wrap;

    // A select that differs from the registered copy restarts both dividers.
    assign rate_change = (baud_sel != sel_q);
    assign rx_wrap     = (rx_cnt == rx_lim);

    // Registered rate select; divisor muxing only ever looks at this copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_q <= 2'b00;
        else       sel_q <= baud_sel;
    end

    // RX terminal-count selection from the registered rate.
    always_comb begin
        rx_lim = RX_LIM_0;
        case (sel_q)
            2'b00:   rx_lim = RX_LIM_0;
            2'b01:   rx_lim = RX_LIM_1;
            2'b10:   rx_lim = RX_LIM_2;
            default: rx_lim = RX_LIM_3;
        endcase
    end

    // RX divider: free-running count, strobe registered on the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_cnt <= 32'd0;
            inrx   <= 1'b0;
        end else if (rate_change) begin
            rx_cnt <= 32'd0;
            inrx   <= 1'b0;
        end else if (rx_wrap) begin
            rx_cnt <= 32'd0;
            inrx   <= 1'b1;
        end else begin
            rx_cnt <= rx_cnt + 32'd1;
            inrx   <= 1'b0;
        end
    end

`ifdef BAUD_TX_FROM_RX_EN
    logic [3:0] sub_cnt;

    // TX strobe rides on every 16th RX wrap, so it always coincides with inrx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_cnt <= 4'd0;
            intx    <= 1'b0;
        end else if (rate_change) begin
            sub_cnt <= 4'd0;
            intx    <= 1'b0;
        end else if (rx_wrap) begin
            sub_cnt <= sub_cnt + 4'd1;
            intx    <= (sub_cnt == 4'd15);
        end else begin
            intx    <= 1'b0;
        end
    end
`else
    // Rounded bit-period divisor.
    function automatic logic [31:0] tx_div(input longint unsigned baud);
        longint unsigned q;
        q = (FREQ + baud / 64'd2) / baud;
        return q[31:0];
    endfunction

    localparam logic [31:0] TX_LIM_0 = tx_div(BAUD_0) - 32'd1;
    localparam logic [31:0] TX_LIM_1 = tx_div(BAUD_1) - 32'd1;
    localparam logic [31:0] TX_LIM_2 = tx_div(BAUD_2) - 32'd1;
    localparam logic [31:0] TX_LIM_3 = tx_div(BAUD_3) - 32'd1;

    logic [31:0] tx_cnt;
    logic [31:0] tx_lim;

    // TX terminal-count selection from the registered rate.
    always_comb begin
        tx_lim = TX_LIM_0;
        case (sel_q)
            2'b00:   tx_lim = TX_LIM_0;
            2'b01:   tx_lim = TX_LIM_1;
            2'b10:   tx_lim = TX_LIM_2;
            default: tx_lim = TX_LIM_3;
        endcase
    end

    // Independent TX divider, same wrap/strobe behaviour as the RX one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt <= 32'd0;
            intx   <= 1'b0;
        end else if (rate_change) begin
            tx_cnt <= 32'd0;
            intx   <= 1'b0;
        end else if (tx_cnt == tx_lim) begin
            tx_cnt <= 32'd0;
            intx   <= 1'b1;
        end else begin
            tx_cnt <= tx_cnt + 32'd1;
            intx   <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_baud_rate_tick_gen.sv
// Directed bench for baud_rate_tick_gen at the default 100 MHz clock.
// A monitor logs the edge index of every strobe; each scenario task drives
// the select/reset at a falling edge and checks first-pulse latency,
// periods, pulse counts and pulse width against hand-computed values.
module tb_baud_rate_tick_gen;

    localparam int RX00 = 651;
    localparam int RX01 = 1302;
    localparam int RX10 = 326;
    localparam int RX11 = 14;
`ifdef BAUD_TX_FROM_RX_EN
    localparam int TX00 = 10416;
    localparam int TX01 = 20832;
    localparam int TX10 = 5216;
    localparam int TX11 = 224;
`else
    localparam int TX00 = 10417;
    localparam int TX01 = 20833;
    localparam int TX10 = 5208;
    localparam int TX11 = 217;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] baud_sel = 2'b00;
    logic       intx;
    logic       inrx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int rx_q[$];
    int tx_q[$];
    int rx_wide = 0;
    int tx_wide = 0;
    logic prev_rx = 1'b0;
    logic prev_tx = 1'b0;

    baud_rate_tick_gen dut (
        .clk(clk),
        .reset(reset),
        .baud_sel(baud_sel),
        .intx(intx),
        .inrx(inrx)
    );

    always #5 clk = ~clk;

    // Edge counter plus strobe log, sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (inrx) begin
            rx_q.push_back(cyc);
            if (prev_rx) rx_wide++;
        end
        if (intx) begin
            tx_q.push_back(cyc);
            if (prev_tx) tx_wide++;
        end
        prev_rx = inrx;
        prev_tx = intx;
    end

    task automatic clear_log();
        rx_q.delete();
        tx_q.delete();
        rx_wide = 0;
        tx_wide = 0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        baud_sel = 2'b00;
        clear_log();
        run(5);
        checks++;
        if (inrx !== 1'b0) begin errors++; $display("FAIL reset_inrx: got %b expected 0", inrx); end
        checks++;
        if (intx !== 1'b0) begin errors++; $display("FAIL reset_intx: got %b expected 0", intx); end
        checks++;
        if (rx_q.size() + tx_q.size() != 0) begin
            errors++; $display("FAIL reset_pulses: got %0d expected 0", rx_q.size() + tx_q.size());
        end
    endtask

    // Release with sel 00 (matches reset value of sel_q): no restart cycle.
    task automatic test_rate_00();
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        clear_log();
        run(TX00 + 5);
        checks++;
        if (rx_q.size() < 1 || rx_q[0] - t0 != RX00) begin
            errors++; $display("FAIL r00_rx_first: got %0d expected %0d", (rx_q.size() > 0) ? rx_q[0] - t0 : -1, RX00);
        end
        checks++;
        if (rx_q.size() < 2 || rx_q[1] - rx_q[0] != RX00) begin
            errors++; $display("FAIL r00_rx_period: got %0d expected %0d", (rx_q.size() > 1) ? rx_q[1] - rx_q[0] : -1, RX00);
        end
        checks++;
        if (rx_q.size() != 16) begin errors++; $display("FAIL r00_rx_count: got %0d expected 16", rx_q.size()); end
        checks++;
        if (tx_q.size() < 1 || tx_q[0] - t0 != TX00) begin
            errors++; $display("FAIL r00_tx_first: got %0d expected %0d", (tx_q.size() > 0) ? tx_q[0] - t0 : -1, TX00);
        end
        checks++;
        if (rx_wide + tx_wide != 0) begin errors++; $display("FAIL r00_width: got %0d wide pulses expected 0", rx_wide + tx_wide); end
    endtask

    task automatic test_rate_11();
        @(negedge clk);
        baud_sel = 2'b11;
        t0 = cyc;
        clear_log();
        run(3000);
        checks++;
        if (rx_q.size() < 1 || rx_q[0] - t0 != RX11 + 1) begin
            errors++; $display("FAIL r11_rx_first: got %0d expected %0d", (rx_q.size() > 0) ? rx_q[0] - t0 : -1, RX11 + 1);
        end
        checks++;
        if (rx_q.size() < 2 || rx_q[1] - rx_q[0] != RX11) begin
            errors++; $display("FAIL r11_rx_period: got %0d expected %0d", (rx_q.size() > 1) ? rx_q[1] - rx_q[0] : -1, RX11);
        end
        checks++;
        if (rx_q.size() != 214) begin errors++; $display("FAIL r11_rx_count: got %0d expected 214", rx_q.size()); end
        checks++;
        if (tx_q.size() < 1 || tx_q[0] - t0 != TX11 + 1) begin
            errors++; $display("FAIL r11_tx_first: got %0d expected %0d", (tx_q.size() > 0) ? tx_q[0] - t0 : -1, TX11 + 1);
        end
        checks++;
        if (tx_q.size() < 3 || tx_q[2] - tx_q[1] != TX11) begin
            errors++; $display("FAIL r11_tx_period: got %0d expected %0d", (tx_q.size() > 2) ? tx_q[2] - tx_q[1] : -1, TX11);
        end
        checks++;
        if (tx_q.size() != 13) begin errors++; $display("FAIL r11_tx_count: got %0d expected 13", tx_q.size()); end
        checks++;
        if (rx_wide + tx_wide != 0) begin errors++; $display("FAIL r11_width: got %0d wide pulses expected 0", rx_wide + tx_wide); end
`ifdef BAUD_TX_FROM_RX_EN
        begin
            int unaligned;
            int between;
            unaligned = 0;
            foreach (tx_q[i]) begin
                int hit;
                hit = 0;
                foreach (rx_q[j]) if (rx_q[j] == tx_q[i]) hit = 1;
                if (hit == 0) unaligned++;
            end
            checks++;
            if (unaligned != 0) begin errors++; $display("FAIL r11_tx_on_rx: got %0d unaligned expected 0", unaligned); end
            between = 0;
            if (tx_q.size() > 1)
                foreach (rx_q[j]) if (rx_q[j] > tx_q[0] && rx_q[j] <= tx_q[1]) between++;
            checks++;
            if (between != 16) begin errors++; $display("FAIL r11_rx_per_tx: got %0d expected 16", between); end
        end
`endif
    endtask

    task automatic test_change_01();
        @(negedge clk);
        baud_sel = 2'b01;
        t0 = cyc;
        clear_log();
        run(TX01 + 3);
        checks++;
        if (rx_q.size() < 1 || rx_q[0] - t0 != RX01 + 1) begin
            errors++; $display("FAIL c01_rx_first: got %0d expected %0d", (rx_q.size() > 0) ? rx_q[0] - t0 : -1, RX01 + 1);
        end
        checks++;
        if (rx_q.size() < 2 || rx_q[1] - rx_q[0] != RX01) begin
            errors++; $display("FAIL c01_rx_period: got %0d expected %0d", (rx_q.size() > 1) ? rx_q[1] - rx_q[0] : -1, RX01);
        end
        checks++;
        if (rx_q.size() != 16) begin errors++; $display("FAIL c01_rx_count: got %0d expected 16", rx_q.size()); end
        checks++;
        if (tx_q.size() != 1 || tx_q[0] - t0 != TX01 + 1) begin
            errors++; $display("FAIL c01_tx_first: got %0d (n=%0d) expected %0d (n=1)", (tx_q.size() > 0) ? tx_q[0] - t0 : -1, tx_q.size(), TX01 + 1);
        end
    endtask

    task automatic test_change_10();
        @(negedge clk);
        baud_sel = 2'b10;
        t0 = cyc;
        clear_log();
        run(TX10 + 3);
        checks++;
        if (rx_q.size() < 1 || rx_q[0] - t0 != RX10 + 1) begin
            errors++; $display("FAIL c10_rx_first: got %0d expected %0d", (rx_q.size() > 0) ? rx_q[0] - t0 : -1, RX10 + 1);
        end
        checks++;
        if (rx_q.size() < 2 || rx_q[1] - rx_q[0] != RX10) begin
            errors++; $display("FAIL c10_rx_period: got %0d expected %0d", (rx_q.size() > 1) ? rx_q[1] - rx_q[0] : -1, RX10);
        end
        checks++;
        if (tx_q.size() != 1 || tx_q[0] - t0 != TX10 + 1) begin
            errors++; $display("FAIL c10_tx_first: got %0d (n=%0d) expected %0d (n=1)", (tx_q.size() > 0) ? tx_q[0] - t0 : -1, tx_q.size(), TX10 + 1);
        end
    endtask

    // Change mid-period straight into the fastest rate: no runt or double pulse.
    task automatic test_back_to_back();
        @(negedge clk);
        baud_sel = 2'b11;
        t0 = cyc;
        clear_log();
        run(300);
        checks++;
        if (rx_q.size() < 1 || rx_q[0] - t0 != RX11 + 1) begin
            errors++; $display("FAIL b2b_rx_first: got %0d expected %0d", (rx_q.size() > 0) ? rx_q[0] - t0 : -1, RX11 + 1);
        end
        checks++;
        if (tx_q.size() != 1 || tx_q[0] - t0 != TX11 + 1) begin
            errors++; $display("FAIL b2b_tx_first: got %0d (n=%0d) expected %0d (n=1)", (tx_q.size() > 0) ? tx_q[0] - t0 : -1, tx_q.size(), TX11 + 1);
        end
        checks++;
        if (rx_wide + tx_wide != 0) begin errors++; $display("FAIL b2b_width: got %0d wide pulses expected 0", rx_wide + tx_wide); end
    endtask

    // Reset lands while inrx is high; it must drop without waiting for an edge.
    // sel_q returns to 00, so releasing with sel 01 costs one restart cycle
    // before the 1302-cycle count.
    task automatic test_async_reset();
        int seen;
        @(negedge clk);
        baud_sel = 2'b01;
        seen = 0;
        for (int i = 0; i < 2000 && seen == 0; i++) begin
            @(negedge clk);
            if (inrx === 1'b1) seen = 1;
        end
        checks++;
        if (seen == 0) begin errors++; $display("FAIL arst_wait_inrx: got no pulse expected one within 2000 cycles"); end
        reset = 1'b1;
        #1;
        checks++;
        if (inrx !== 1'b0) begin errors++; $display("FAIL arst_inrx_drop: got %b expected 0", inrx); end
        repeat (3) @(negedge clk);
        checks++;
        if (inrx !== 1'b0 || intx !== 1'b0) begin
            errors++; $display("FAIL arst_hold: got inrx=%b intx=%b expected 0 0", inrx, intx);
        end
        reset = 1'b0;
        t0 = cyc;
        clear_log();
        run(RX01 + 3);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] - t0 != RX01 + 1) begin
            errors++; $display("FAIL arst_rx_first: got %0d (n=%0d) expected %0d (n=1)", (rx_q.size() > 0) ? rx_q[0] - t0 : -1, rx_q.size(), RX01 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_rate_00();
        test_rate_11();
        test_change_01();
        test_change_10();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
